pattern_sequencer: RTL
======================

# pattern_sequencer

Four-output LED/pattern sequencer for the tile's core. It drives O_0..O_3, which the top-level shell routes to io_out[3:0]; its control inputs come from io_in[7:2]. A prescaler sets the step rate, and a mode selects one of four sequence generators. All state is clocked on CLK with a synchronous active-low reset.

## Interface
Parameters:
- PRESCALE_W, default 8: prescaler width. Must be ≥ 7 so that SPEED=7 is reachable.

Ports:
- CLK  in  1  design clock (io_in[0])
- RST  in  1  reset, synchronous, active-low (io_in[1]); 0 = reset on the next CLK rising edge
- HOLD  in  1  1 = freeze prescaler, state and direction (io_in[2])
- MODE  in  2  sequence select (io_in[4:3])
- SPEED  in  3  step period = 2^SPEED cycles (io_in[7:5])
- O_0..O_3  out  1 each  pattern bits 0..3, driven directly from the state register

## Operation
- Registers:
  - state[3:0]
  - mode_q[1:0]
  - dir (1 = up)
  - pre[PRESCALE_W-1:0]
- Reset (RST=0 at an edge) overrides everything: state=0000, mode_q=00, dir=1, pre=0. All outputs are 0 from that edge onward.
- Priority order, evaluated each edge with RST=1:
  1. Mode change: if MODE≠mode_q, then mode_q←MODE, pre←0, dir←1, and state←seed. Seed is 0000 for modes 00 and 01, and 0001 for modes 10 and 11. This takes effect regardless of HOLD.
  2. HOLD=1: all registers keep their values.
  3. Tick: if pre ≥ (2^SPEED)−1, then pre←0 and state steps once. Otherwise pre←pre+1 and state holds.
- Comparison is ≥, not ==. If SPEED is lowered below the current pre, the next edge ticks, with no 2^PRESCALE_W wrap.
- Step rules (4-bit, modulo 16):
  - Mode 00, binary: state←state+1. 1111 wraps to 0000.
  - Mode 01, Johnson: state←{state[2:0], ~state[3]}. This is an 8-state cycle: 0000,0001,0011,0111,1111,1110,1100,1000.
  - Mode 10, bounce (one-hot):
    - dir=1: shift left. On reaching 1000, set dir←0.
    - dir=0: shift right. On reaching 0001, set dir←1.
    - Sequence: 0001,0010,0100,1000,0100,0010,0001,0010… with no repeated end states.
    - If state is not one-hot (unreachable by design), the next step loads 0001 and sets dir=1.
  - Mode 11, LFSR (x^4+x^3+1): state←{state[2:0], state[3]^state[2]}. The cycle covers all 15 nonzero values from seed 0001. If state=0000, the next step loads 0001.

## Timing
- Outputs change only on CLK rising edges.
- O_n = state[n], with zero combinational path from the inputs.
- First step after reset release, MODE=00, SPEED=s, HOLD=0: the state reads 0001 after 2^s edges with RST=1.
- Mode change: the seed is visible one edge after MODE is first sampled different. The first step follows 2^SPEED edges later.
- If MODE≠00 during the first edge after reset release, that edge performs the mode reload (seed load). No step occurs on that edge.
- HOLD asserted: freeze starts at the same edge. HOLD deasserted: counting resumes from the frozen pre value. No tick is lost or duplicated.
- Reset asserted mid-sequence: next edge gives outputs 0000, mode_q=00, pre=0. This applies regardless of HOLD or MODE.
- SPEED is sampled every edge, with no registering. Changing SPEED never reloads the state.

## Configuration
- PATTERN_LFSR_EN:
  - Defined: mode 11 is the LFSR as above.
  - Undefined: the LFSR logic is not built. Mode 11 behaves exactly as mode 00 (seed 0000, binary count), and mode-change detection between 00 and 11 still reloads.

## Test plan
- Reset/binary: hold RST=0 for 2 edges, then RST=1, MODE=00, SPEED=0, HOLD=0 → O[3:0] reads 0000 under reset, then 0001, 0010 … 1111, 0000 on successive edges (wrap at edge 16).
- Prescaler: MODE=00, SPEED=3 → state increments every 8 edges. Then drop SPEED to 1 when pre=5 → tick on the next edge, then every 2 edges.
- Johnson/bounce: MODE=01, SPEED=0 → 8-state sequence repeating from 0000. Switch to MODE=10 → 0001, then 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- LFSR: MODE=11, SPEED=0 with PATTERN_LFSR_EN defined → 15 distinct nonzero values, then back to 0001 and never 0000. With the macro undefined → the binary count from 0000.
- HOLD/mode change: HOLD=1 at state 0101 for 20 edges → output stays 0101 and pre is unchanged. With HOLD still 1, change MODE 00→10 → 0001 next edge, then frozen.
- Reset mid-run: assert RST=0 in mode 10 at 0100 with dir=0 → 0000 on the next edge. Release with MODE=10 → 0001 after one edge, and dir=1.

Source files
------------

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: four-bit step sequencer (binary, Johnson, bounce, LFSR) paced by a 2^SPEED prescaler.
// Latency: O_0..O_3 come straight from the state register; a step lands on the edge that sees the tick.
// Backpressure: none; HOLD freezes prescaler, state and direction. Mode 11 LFSR is built only with PATTERN_LFSR_EN.
module pattern_sequencer #(
   parameter int PRESCALE_W = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       HOLD,
   input  logic [1:0] MODE,
   input  logic [2:0] SPEED,
   output logic       O_0,
   output logic       O_1,
   output logic       O_2,
   output logic       O_3
);

   typedef enum logic [1:0] {
      MODE_BIN    = 2'b00,
      MODE_JOHN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_LFSR   = 2'b11
   } mode_t;

   logic [3:0]            state, state_nxt;
   logic [3:0]            step_val, seed;
   mode_t                 mode_q, mode_nxt, mode_in;
   logic                  dir, dir_nxt, step_dir;
   logic [PRESCALE_W-1:0] pre, pre_nxt, limit;
   logic [7:0]            limit8;
   logic                  tick;

   assign mode_in = mode_t'(MODE);

   // Greater-or-equal lets a lowered SPEED tick immediately instead of waiting for pre to wrap.
   assign limit8 = (8'd1 << SPEED) - 8'd1;
   assign limit  = PRESCALE_W'(limit8);
   assign tick   = (pre >= limit);

   always_comb begin
      seed = 4'b0000;
      if (mode_in == MODE_BOUNCE) begin
         seed = 4'b0001;
      end
`ifdef PATTERN_LFSR_EN
      if (mode_in == MODE_LFSR) begin
         seed = 4'b0001;
      end
`endif
   end

   always_comb begin
      step_val = state + 4'd1;
      step_dir = dir;
      case (mode_q)
         MODE_JOHN: begin
            step_val = {state[2:0], ~state[3]};
         end
         MODE_BOUNCE: begin
            if (!$onehot(state)) begin
               step_val = 4'b0001;
               step_dir = 1'b1;
            end else if (dir) begin
               if (state[3]) begin
                  step_val = 4'b0100;
                  step_dir = 1'b0;
               end else begin
                  step_val = state << 1;
                  step_dir = ~state[2];
               end
            end else begin
               if (state[0]) begin
                  step_val = 4'b0010;
                  step_dir = 1'b1;
               end else begin
                  step_val = state >> 1;
                  step_dir = state[1];
               end
            end
         end
`ifdef PATTERN_LFSR_EN
         MODE_LFSR: begin
            // All-zero is the LFSR lock-up state, so it is forced back onto the cycle.
            if (state == 4'b0000) begin
               step_val = 4'b0001;
            end else begin
               step_val = {state[2:0], state[3] ^ state[2]};
            end
         end
`endif
         default: begin
            step_val = state + 4'd1;
         end
      endcase
   end

   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      dir_nxt   = dir;
      pre_nxt   = pre;
      if (mode_in != mode_q) begin
         mode_nxt  = mode_in;
         pre_nxt   = '0;
         dir_nxt   = 1'b1;
         state_nxt = seed;
      end else if (!HOLD) begin
         if (tick) begin
            pre_nxt   = '0;
            state_nxt = step_val;
            dir_nxt   = step_dir;
         end else begin
            pre_nxt = pre + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state  <= 4'b0000;
         mode_q <= MODE_BIN;
         dir    <= 1'b1;
         pre    <= '0;
      end else begin
         state  <= state_nxt;
         mode_q <= mode_nxt;
         dir    <= dir_nxt;
         pre    <= pre_nxt;
      end
   end

   assign O_0 = state[0];
   assign O_1 = state[1];
   assign O_2 = state[2];
   assign O_3 = state[3];

endmodule
